// File: rtl/memory_pkg.sv
// Shared types and helpers for the banked read/write memory and its response pipeline.
package memory_pkg;

    typedef enum logic {CLEAR, READY} mem_state_t;

    localparam int LANE_BITS = 8;

    function automatic logic lane_parity(input logic [LANE_BITS-1:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/memory_rsp_pipe.sv
// Fixed-latency response shift pipeline carrying {valid, rdata, err, perr}; cleared by rst.
module memory_rsp_pipe #(
    parameter int READ_LATENCY = 1,
    parameter int WORD_SIZE    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] in_rdata,
    input  logic                 in_err,
    input  logic                 in_perr,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] out_rdata,
    output logic                 out_err,
    output logic                 out_perr
);

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] err_q, err_d;
    logic [READ_LATENCY-1:0] perr_q, perr_d;
    logic [WORD_SIZE-1:0]    data_q [READ_LATENCY];
    logic [WORD_SIZE-1:0]    data_d [READ_LATENCY];

    always_comb begin
        vld_d     = vld_q;
        err_d     = err_q;
        perr_d    = perr_q;
        data_d    = data_q;
        vld_d[0]  = in_valid;
        err_d[0]  = in_err;
        perr_d[0] = in_perr;
        data_d[0] = in_rdata;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            err_d[i]  = err_q[i-1];
            perr_d[i] = perr_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            err_q  <= '0;
            perr_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= '0;
        end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            perr_q <= perr_d;
            data_q <= data_d;
        end
    end

    assign out_valid = vld_q[READ_LATENCY-1];
    assign out_rdata = data_q[READ_LATENCY-1];
    assign out_err   = err_q[READ_LATENCY-1];
    assign out_perr  = perr_q[READ_LATENCY-1];

endmodule

// File: rtl/memory_banked_rw.sv
// Byte-lane RAM with valid/ready requests, fixed-latency responses and a hardware clear sequencer.
// Optional per-lane parity storage and checking enabled by defining MEMORY_PARITY_EN.
module memory_banked_rw
    import memory_pkg::*;
#(
    parameter int  WORD_SIZE    = 16,
    parameter int  ADDR_SIZE    = 16,
    parameter int  DEPTH        = 1 << ADDR_SIZE,
    parameter int  READ_LATENCY = 1,
    localparam int LANES        = WORD_SIZE / LANE_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    input  logic [LANES-1:0]     req_be,
    output logic                 rsp_valid,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_perr,
    output logic                 busy
);

    localparam int                 AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_SIZE:0] DEPTH_EXT = (ADDR_SIZE + 1)'(DEPTH);

    if (WORD_SIZE % LANE_BITS != 0) begin : g_bad_word
        $error("WORD_SIZE must be a multiple of 8");
    end

    logic [WORD_SIZE-1:0] mem [DEPTH];
`ifdef MEMORY_PARITY_EN
    logic [LANES-1:0]     par_mem [DEPTH];
`endif

    mem_state_t           state_q, state_d;
    logic [AW-1:0]        clear_addr_q, clear_addr_d;
    logic [AW-1:0]        idx;
    logic                 in_range, accept, wr_en, rd_en;
    logic [WORD_SIZE-1:0] rd_word, pipe_rdata;
    logic                 pipe_err, pipe_perr;

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        busy         = 1'b1;
        req_ready    = 1'b0;
        case (state_q)
            CLEAR: begin
                clear_addr_d = clear_addr_q + 1'b1;
                if (clear_addr_q == AW'(DEPTH - 1)) begin
                    state_d      = READY;
                    clear_addr_d = '0;
                end
            end
            READY: begin
                busy      = 1'b0;
                req_ready = 1'b1;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clear_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    // Out-of-range requests never touch the array; they only produce an error response.
    assign in_range = {1'b0, req_addr} < DEPTH_EXT;
    assign idx      = req_addr[AW-1:0];
    assign accept   = req_valid & req_ready & ~rst;
    assign wr_en    = accept & req_we & in_range;
    assign rd_en    = accept & ~req_we & in_range;
    assign rd_word  = mem[idx];

    always_comb begin
        pipe_rdata = rd_en ? rd_word : '0;
        pipe_err   = accept & ~in_range;
        pipe_perr  = 1'b0;
`ifdef MEMORY_PARITY_EN
        for (int l = 0; l < LANES; l++) begin
            pipe_perr = pipe_perr |
                (lane_parity(rd_word[l*LANE_BITS +: LANE_BITS]) ^ par_mem[idx][l]);
        end
        pipe_perr = pipe_perr & rd_en;
`endif
    end

    always_ff @(posedge clk) begin
        if (state_q == CLEAR && !rst) begin
            mem[clear_addr_q] <= '0;
`ifdef MEMORY_PARITY_EN
            par_mem[clear_addr_q] <= '0;
`endif
        end else if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (req_be[l]) begin
                    mem[idx][l*LANE_BITS +: LANE_BITS] <= req_wdata[l*LANE_BITS +: LANE_BITS];
`ifdef MEMORY_PARITY_EN
                    par_mem[idx][l] <= lane_parity(req_wdata[l*LANE_BITS +: LANE_BITS]);
`endif
                end
            end
        end
    end

    memory_rsp_pipe #(
        .READ_LATENCY(READ_LATENCY),
        .WORD_SIZE   (WORD_SIZE)
    ) u_rsp_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept),
        .in_rdata (pipe_rdata),
        .in_err   (pipe_err),
        .in_perr  (pipe_perr),
        .out_valid(rsp_valid),
        .out_rdata(rsp_rdata),
        .out_err  (rsp_err),
        .out_perr (rsp_perr)
    );

endmodule

// File: doc/memory_banked_rw.md
Name: memory_banked_rw

Overview:
- Parametrised successor to the plain single-port RAM.
- Replaces the tri-state data_out and the single-cycle reset clear with three things:
  - a valid/ready request channel with per-byte write enables;
  - a fixed-latency response pipeline with an error flag for out-of-range addresses;
  - a multi-cycle hardware clear sequencer.
- Sits between the CPU/bus interconnect and the system memory map.

Parameters:
- WORD_SIZE, 16, data word width in bits; must be a multiple of 8, otherwise elaboration fails.
- ADDR_SIZE, 16, request address width in bits.
- DEPTH, 1<<ADDR_SIZE, number of implemented words, 1..2^ADDR_SIZE; need not be a power of two.
- READ_LATENCY, 1, cycles from request acceptance to rsp_valid, 1..4.
- LANES, WORD_SIZE/8 (localparam), number of byte lanes.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_SIZE  word address
- req_wdata  in  WORD_SIZE  write data
- req_be  in  LANES  byte-lane write enables; lane i covers bits 8i+7:8i
- rsp_valid  out  1  response strobe, one cycle per accepted request
- rsp_rdata  out  WORD_SIZE  read data; 0 for writes and errors
- rsp_err  out  1  address was >= DEPTH
- rsp_perr  out  1  parity error on read; 0 unless MEMORY_PARITY_EN
- busy  out  1  clear sequence in progress

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- State machine has two states, CLEAR and READY.
  - rst forces CLEAR and clear_addr=0 at the next edge.
  - In CLEAR: each cycle write 0 to ram[clear_addr], increment clear_addr.
  - CLEAR -> READY on the edge that writes word DEPTH-1, so CLEAR lasts exactly DEPTH cycles after rst deasserts.
  - rst asserted mid-clear restarts the sequence from address 0.
- Output values by state:
  - CLEAR: busy=1, req_ready=0.
  - READY: busy=0, req_ready=1.
- Reset values: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_perr=0. The response pipeline is flushed.
- Handshake:
  - A request is accepted on an edge where req_valid & req_ready.
  - One request per cycle, no stalls in READY.
  - No response backpressure.
- Write accepted at edge N:
  - For each lane with req_be[i]=1, ram[addr] lane i <= req_wdata lane i.
  - Other lanes are unchanged.
  - req_be=0 is a legal no-op write and still produces a response.
- Read accepted at edge N:
  - Array is sampled at edge N. A write accepted at edge N-1 or earlier is visible.
  - Data emerges with rsp_valid=1 on the cycle after edge N+READ_LATENCY-1, i.e. READ_LATENCY=1 gives the response in the cycle immediately following acceptance.
- Every accepted request produces exactly one response, in acceptance order, with the same latency for reads and writes.
  - Writes respond with rsp_rdata=0, rsp_err=0.
- Address >= DEPTH:
  - No array access; write data is dropped.
  - Response has rsp_err=1, rsp_rdata=0.
- rsp_rdata, rsp_err and rsp_perr are 0 whenever rsp_valid=0.
- Back-to-back requests fill the pipeline: continuous throughput of 1 response per cycle.

Optional Feature:
- Macro: MEMORY_PARITY_EN.
- Defined:
  - One even-parity bit per byte lane is stored in array par_mem[DEPTH][LANES].
  - par_mem is written alongside data under the same lane enables; clear writes parity 0.
  - On read, rsp_perr = OR over lanes of (^data_lane ^ par_lane), aligned with rsp_valid.
  - rsp_perr=0 for writes and errors.
- Undefined: no par_mem, rsp_perr tied 0.

Decomposition:
- Package memory_pkg holds:
  - state enum mem_state_t {CLEAR, READY};
  - constant LANE_BITS=8;
  - function lane_parity(lane) returning the XOR reduction.
- Sub-module memory_rsp_pipe:
  - parametrised by READ_LATENCY and WORD_SIZE;
  - a shift pipeline carrying {valid, rdata, err, perr};
  - synchronous clear on rst.
- The top holds the array, FSM, clear counter and lane-write logic.

Test Plan:
- Clear and ready: DEPTH=16. Pulse rst 1 cycle -> busy=1 and req_ready=0 for exactly 16 cycles, then busy=0 and req_ready=1. A read of every address returns 0.
- Lane writes: READY, WORD_SIZE=16, READ_LATENCY=1.
  - Write addr 3, data 0xABCD, be=2'b11; then write addr 3, data 0x1234, be=2'b01.
  - Read addr 3 -> rsp_rdata=0xAB34 one cycle after acceptance.
- Latency and throughput: READ_LATENCY=3. Write addrs 0..3 with 0x10..0x13, then reads of 0..3 on 4 consecutive cycles -> rsp_valid high for 4 consecutive cycles starting 3 cycles after the first read; data 0x10,0x11,0x12,0x13.
- Out of range: DEPTH=10.
  - Write addr 12, data 0xFFFF -> response rsp_err=1.
  - Read addr 12 -> rsp_err=1, rsp_rdata=0.
  - Read addr 2 -> unchanged value.
- Reset mid-clear and mid-traffic:
  - Assert rst at clear cycle 5 -> clear restarts; busy for a full DEPTH cycles after rst drops.
  - Assert rst with 2 reads in flight -> no rsp_valid after reset.
- Parity (MEMORY_PARITY_EN): write addr 7 = 0x00FF. Deposit par_mem[7][0] inverted via hierarchy. Read addr 7 -> rsp_perr=1, rsp_rdata=0x00FF. Without the macro, the same read gives rsp_perr=0.
